// File: rtl/ram_scan_ctrl.sv
// RAM read-scan sequencer: walks [first, last] with a programmable stride,
// drives RAM address/read-enable and a read-latency-aligned data-valid strobe.
// Supports single/continuous passes, abort, a saturating pass counter and
// done / config-error pulses.
module ram_scan_ctrl #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned PRE_DELAY = 2,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned PASS_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start_scan,
    input  logic              i_abort,
    input  logic              i_mode_cont,
    input  logic [ADDR_W-1:0] i_first_addr,
    input  logic [ADDR_W-1:0] i_last_addr,
    input  logic [3:0]        i_stride,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_en,
    output logic              o_data_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cfg_err,
    output logic [PASS_W-1:0] o_pass_cnt
);

    // One down-counter serves both the pre-read delay and the drain phase.
    localparam int unsigned MAX_WAIT = (PRE_DELAY > RD_LAT) ? PRE_DELAY : RD_LAT;
    localparam int unsigned CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'((PRE_DELAY == 0) ? 0 : PRE_DELAY - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'((RD_LAT == 0) ? 0 : RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRead, StDrain} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_first;
    logic [ADDR_W-1:0]   r_last;
    logic [3:0]          r_stride;
    logic                r_mode_cont;
    logic                r_aborted;
    logic                r_ram_en;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_done;
    logic                r_cfg_err;
    logic [PASS_W-1:0]   r_pass_cnt;

    logic [3:0]          w_stride_eff;
    logic [ADDR_W:0]     w_next_addr;
    logic                w_final;
    logic                w_set_done;

    // Next address is formed one bit wider so a step past the top of the
    // address space reads as "beyond last" instead of wrapping to zero.
    always_comb begin
        w_stride_eff = (r_stride == 4'd0) ? 4'd1 : r_stride;
        w_next_addr  = {1'b0, r_ram_addr} + (ADDR_W + 1)'(w_stride_eff);
        w_final      = (w_next_addr > {1'b0, r_last});
    end

    // Done is registered, so it is raised on the edge entering the last drain
    // cycle (or the cycle after the final read when there is no drain).
    always_comb begin
        w_set_done = 1'b0;
        if (!i_abort) begin
            if ((r_state == StRead) && w_final && (RD_LAT <= 1)) begin
                w_set_done = 1'b1;
            end
            if ((r_state == StDrain) && !r_aborted && (r_cnt == CNT_W'(1)) && (RD_LAT >= 2)) begin
                w_set_done = 1'b1;
            end
        end
    end

    // Scan FSM with registered address/enable/done/error/pass-count outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_first     <= '0;
            r_last      <= '0;
            r_stride    <= '0;
            r_mode_cont <= 1'b0;
            r_aborted   <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_addr  <= '0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_pass_cnt  <= '0;
        end else begin
            r_done    <= w_set_done;
            r_cfg_err <= 1'b0;
            if (w_set_done && (r_pass_cnt != '1)) begin
                r_pass_cnt <= r_pass_cnt + PASS_W'(1);
            end

            unique case (r_state)
                StIdle: begin
                    if (i_start_scan) begin
                        if (i_first_addr > i_last_addr) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_first     <= i_first_addr;
                            r_last      <= i_last_addr;
                            r_stride    <= i_stride;
                            r_mode_cont <= i_mode_cont;
                            r_pass_cnt  <= '0;
                            r_aborted   <= 1'b0;
                            if (PRE_DELAY == 0) begin
                                r_state    <= StRead;
                                r_ram_en   <= 1'b1;
                                r_ram_addr <= i_first_addr;
                            end else begin
                                r_state <= StDelay;
                                r_cnt   <= PRE_LOAD;
                            end
                        end
                    end
                end

                StDelay: begin
                    if (i_abort) begin
                        if (RD_LAT == 0) begin
                            r_state <= StIdle;
                        end else begin
                            r_state   <= StDrain;
                            r_cnt     <= LAT_LOAD;
                            r_aborted <= 1'b1;
                        end
                    end else if (r_cnt == '0) begin
                        r_state    <= StRead;
                        r_ram_en   <= 1'b1;
                        r_ram_addr <= r_first;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                StRead: begin
                    if (i_abort || w_final) begin
                        r_ram_en   <= 1'b0;
                        r_ram_addr <= '0;
                        if (RD_LAT != 0) begin
                            r_state   <= StDrain;
                            r_cnt     <= LAT_LOAD;
                            r_aborted <= i_abort;
                        end else if (i_abort || !r_mode_cont) begin
                            r_state <= StIdle;
                        end else if (PRE_DELAY == 0) begin
                            r_ram_en   <= 1'b1;
                            r_ram_addr <= r_first;
                        end else begin
                            r_state <= StDelay;
                            r_cnt   <= PRE_LOAD;
                        end
                    end else begin
                        r_ram_addr <= w_next_addr[ADDR_W-1:0];
                    end
                end

                StDrain: begin
                    if (i_abort) begin
                        r_state <= StIdle;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (r_aborted || !r_mode_cont) begin
                        r_state <= StIdle;
                    end else if (PRE_DELAY == 0) begin
                        r_state    <= StRead;
                        r_ram_en   <= 1'b1;
                        r_ram_addr <= r_first;
                    end else begin
                        r_state <= StDelay;
                        r_cnt   <= PRE_LOAD;
                    end
                end

                default: r_state <= StIdle;
            endcase
        end
    end

    // Valid strobe is the read enable delayed by the RAM read latency; reads
    // already issued keep flowing through even after an abort.
    generate
        if (RD_LAT == 0) begin : g_no_lat
            assign o_data_valid = r_ram_en;
        end else begin : g_lat
            logic [RD_LAT-1:0] r_vld_pipe;

            // Shift read enables down the latency line.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld_pipe <= '0;
                end else begin
                    for (int i = 1; i < int'(RD_LAT); i++) begin
                        r_vld_pipe[i] <= r_vld_pipe[i-1];
                    end
                    r_vld_pipe[0] <= r_ram_en;
                end
            end

            assign o_data_valid = r_vld_pipe[RD_LAT-1];
        end
    endgenerate

    assign o_ram_addr = r_ram_addr;
    assign o_ram_en   = r_ram_en;
    assign o_busy     = (r_state != StIdle);
    assign o_done     = r_done;
    assign o_cfg_err  = r_cfg_err;
    assign o_pass_cnt = r_pass_cnt;

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Self-checking bench for ram_scan_ctrl: a per-cycle expectation timeline is
// built from the scan rules (read count, stride grid, delays, abort/reset
// effects) and compared against the DUT on every cycle, plus literal checks.
module tb_ram_scan_ctrl;

    localparam int AW      = 10;
    localparam int PD      = 2;
    localparam int RL      = 2;
    localparam int PW      = 16;
    localparam int MAXC    = 40000;
    localparam int HORIZON = 2500;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start_scan = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_mode_cont = 1'b0;
    logic [AW-1:0] i_first_addr = '0;
    logic [AW-1:0] i_last_addr = '0;
    logic [3:0]    i_stride = '0;
    logic [AW-1:0] o_ram_addr;
    logic          o_ram_en;
    logic          o_data_valid;
    logic          o_busy;
    logic          o_done;
    logic          o_cfg_err;
    logic [PW-1:0] o_pass_cnt;

    ram_scan_ctrl #(
        .ADDR_W   (AW),
        .PRE_DELAY(PD),
        .RD_LAT   (RL),
        .PASS_W   (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start_scan(i_start_scan),
        .i_abort     (i_abort),
        .i_mode_cont (i_mode_cont),
        .i_first_addr(i_first_addr),
        .i_last_addr (i_last_addr),
        .i_stride    (i_stride),
        .o_ram_addr  (o_ram_addr),
        .o_ram_en    (o_ram_en),
        .o_data_valid(o_data_valid),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_cfg_err   (o_cfg_err),
        .o_pass_cnt  (o_pass_cnt)
    );

    always #5 clk = ~clk;

    // cyc = k during the period that follows rising edge k
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected timeline, indexed by cycle
    bit e_en    [MAXC];
    int e_addr  [MAXC];
    bit e_val   [MAXC];
    bit e_done  [MAXC];
    bit e_busy  [MAXC];
    bit e_cfg   [MAXC];
    bit e_drain [MAXC];
    bit e_clr   [MAXC];
    int sched_end = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int last_start_e = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d: wait bound expired", name, cyc);
    endfunction

    // Start request seen in cycle c; takes effect at edge c+1 if idle then.
    function automatic void model_start(input int c, input int first, input int last,
                                        input int stride, input bit cont);
        int e, se, n, r0, lr, dn;
        e = c + 1;
        if (e_busy[c]) return;
        if (first > last) begin
            e_cfg[e] = 1'b1;
            return;
        end
        e_clr[e] = 1'b1;
        se = (stride == 0) ? 1 : stride;
        n  = (last - first) / se + 1;
        r0 = e + PD;
        forever begin
            for (int i = 0; i < n; i++) begin
                if (r0 + i + RL < MAXC) begin
                    e_en[r0 + i]     = 1'b1;
                    e_addr[r0 + i]   = first + i * se;
                    e_val[r0 + i + RL] = 1'b1;
                end
            end
            lr = r0 + n - 1;
            dn = lr + ((RL == 0) ? 1 : RL);
            for (int k = r0 - PD; k <= dn; k++) if (k < MAXC) e_busy[k] = 1'b1;
            for (int k = lr + 1; k <= dn; k++) if (k < MAXC) e_drain[k] = 1'b1;
            if (dn < MAXC) e_done[dn] = 1'b1;
            if (dn + RL + 2 > sched_end) sched_end = dn + RL + 2;
            if (!cont || r0 > e + HORIZON) break;
            r0 = dn + 1 + PD;
        end
    endfunction

    // Wipe everything the scan would have done after cycle a (in-flight valids stay).
    function automatic void clear_after(input int a);
        for (int k = a + 1; k <= sched_end && k < MAXC; k++) begin
            e_en[k]    = 1'b0;
            e_addr[k]  = 0;
            e_done[k]  = 1'b0;
            e_busy[k]  = 1'b0;
            e_drain[k] = 1'b0;
            if (k > a + RL) e_val[k] = 1'b0;
        end
    endfunction

    // Abort seen in cycle c: draining scans stop at once, others drain RL cycles.
    function automatic void model_abort(input int c);
        bit was_drain;
        if (!e_busy[c]) return;
        was_drain = e_drain[c];
        clear_after(c);
        if (!was_drain) begin
            for (int k = c + 1; k <= c + RL; k++) begin
                e_busy[k]  = 1'b1;
                e_drain[k] = 1'b1;
            end
        end
    endfunction

    // Reset asserted in cycle c hits at edge c+1: everything quiet from then on.
    function automatic void model_reset(input int c);
        for (int k = c + 1; k <= sched_end + RL && k < MAXC; k++) begin
            e_en[k]    = 1'b0;
            e_addr[k]  = 0;
            e_val[k]   = 1'b0;
            e_done[k]  = 1'b0;
            e_busy[k]  = 1'b0;
            e_drain[k] = 1'b0;
            e_cfg[k]   = 1'b0;
        end
        e_clr[c + 1] = 1'b1;
    endfunction

    // Observations of the DUT used by the literal checks
    int o_n_en, o_n_val, o_n_done, o_n_cfg, o_n_busy;
    int o_first_en, o_first_addr, o_last_addr, o_gap, o_fall;
    bit prev_en;
    int mp = 0;

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            if (e_clr[cyc]) mp = 0;
            if (e_done[cyc] && mp < 65535) mp++;
            chk("ram_en",     o_ram_en,     e_en[cyc]);
            chk("ram_addr",   o_ram_addr,   e_en[cyc] ? e_addr[cyc] : 0);
            chk("data_valid", o_data_valid, e_val[cyc]);
            chk("done",       o_done,       e_done[cyc]);
            chk("busy",       o_busy,       e_busy[cyc]);
            chk("cfg_err",    o_cfg_err,    e_cfg[cyc]);
            chk("pass_cnt",   o_pass_cnt,   mp);

            if (o_ram_en) begin
                o_n_en++;
                if (o_first_en < 0) begin
                    o_first_en   = cyc;
                    o_first_addr = int'(o_ram_addr);
                end
                if (!prev_en && o_fall >= 0) o_gap = cyc - o_fall;
                o_last_addr = int'(o_ram_addr);
            end else if (prev_en) begin
                o_fall = cyc;
            end
            prev_en = o_ram_en;
            if (o_data_valid) o_n_val++;
            if (o_done)       o_n_done++;
            if (o_cfg_err)    o_n_cfg++;
            if (o_busy)       o_n_busy++;
        end
    end

    task automatic obs_clear();
        o_n_en = 0; o_n_val = 0; o_n_done = 0; o_n_cfg = 0; o_n_busy = 0;
        o_first_en = -1; o_first_addr = -1; o_last_addr = -1; o_gap = -1; o_fall = -1;
        prev_en = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        i_start_scan = 1'b0;
        i_abort      = 1'b0;
    endtask

    task automatic start_scan(input int first, input int last, input int stride, input bit cont);
        step();
        i_first_addr = AW'(first);
        i_last_addr  = AW'(last);
        i_stride     = 4'(stride);
        i_mode_cont  = cont;
        i_start_scan = 1'b1;
        last_start_e = cyc + 1;
        model_start(cyc, first, last, stride, cont);
    endtask

    task automatic abort_now();
        step();
        i_abort = 1'b1;
        model_abort(cyc);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        do begin
            step();
            k++;
        end while (o_busy && k < budget);
        if (o_busy) timeout(name);
        repeat (RL + 1) step();
    endtask

    initial begin
        int k;
        obs_clear();
        repeat (3) step();
        rst = 1'b0;
        step();

        // Full default window, single pass
        obs_clear();
        start_scan(0, 575, 1, 0);
        wait_idle(800, "wait_full");
        chk("lit_first_read_offset", o_first_en - last_start_e, 2);
        chk("lit_full_reads", o_n_en, 576);
        chk("lit_full_valids", o_n_val, 576);
        chk("lit_full_done", o_n_done, 1);
        chk("lit_full_last_addr", o_last_addr, 575);
        chk("lit_full_pass_cnt", o_pass_cnt, 1);
        chk("lit_full_busy_after", o_busy, 0);

        // Stride grid: 3,7,11,15,19 then stride 0 -> every address
        obs_clear();
        start_scan(3, 20, 4, 0);
        wait_idle(100, "wait_s4");
        chk("lit_s4_reads", o_n_en, 5);
        chk("lit_s4_last_addr", o_last_addr, 19);
        obs_clear();
        start_scan(3, 20, 0, 0);
        wait_idle(100, "wait_s0");
        chk("lit_s0_reads", o_n_en, 18);
        chk("lit_s0_first_addr", o_first_addr, 3);
        chk("lit_s0_last_addr", o_last_addr, 20);

        // Top of address space: no wrap
        obs_clear();
        start_scan(1020, 1023, 8, 0);
        wait_idle(100, "wait_top");
        chk("lit_top_reads", o_n_en, 1);
        chk("lit_top_addr", o_last_addr, 1020);
        chk("lit_top_done", o_n_done, 1);

        // Continuous: three passes, then abort on the second read of pass four
        obs_clear();
        start_scan(10, 13, 1, 1);
        k = 0;
        do begin step(); k++; end while (o_n_done < 3 && k < 200);
        if (o_n_done < 3) timeout("wait_cont_done");
        repeat (3) step();
        abort_now();
        wait_idle(100, "wait_cont_abort");
        chk("lit_cont_reads", o_n_en, 14);
        chk("lit_cont_valids", o_n_val, 14);
        chk("lit_cont_done", o_n_done, 3);
        chk("lit_cont_pass_cnt", o_pass_cnt, 3);
        chk("lit_cont_gap", o_gap, 4);

        // Bad window rejected, then a start while busy is ignored
        obs_clear();
        start_scan(50, 40, 1, 0);
        repeat (4) step();
        chk("lit_cfg_err_pulses", o_n_cfg, 1);
        chk("lit_cfg_err_busy", o_n_busy, 0);
        obs_clear();
        start_scan(0, 30, 1, 0);
        repeat (10) step();
        i_first_addr = AW'(5);
        i_last_addr  = AW'(6);
        i_start_scan = 1'b1;
        model_start(cyc, 5, 6, 1, 0);
        wait_idle(100, "wait_busy_start");
        chk("lit_ign_reads", o_n_en, 31);
        chk("lit_ign_first", o_first_addr, 0);
        chk("lit_ign_last", o_last_addr, 30);
        chk("lit_ign_done", o_n_done, 1);

        // Reset on read 100, then a fresh scan
        obs_clear();
        start_scan(0, 575, 1, 0);
        k = 0;
        do begin step(); k++; end while (o_n_en < 100 && k < 300);
        if (o_n_en < 100) timeout("wait_read100");
        rst = 1'b1;
        model_reset(cyc);
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("lit_rst_done", o_n_done, 0);
        chk("lit_rst_pass_cnt", o_pass_cnt, 0);
        chk("lit_rst_busy", o_busy, 0);
        obs_clear();
        start_scan(5, 9, 1, 0);
        wait_idle(100, "wait_after_rst");
        chk("lit_post_rst_reads", o_n_en, 5);
        chk("lit_post_rst_offset", o_first_en - last_start_e, 2);
        chk("lit_post_rst_pass_cnt", o_pass_cnt, 1);

        // Randomized scans with input churn, stray starts, aborts and resets
        for (int it = 0; it < 40; it++) begin
            int first, last, stride, len;
            bit cont;
            first  = int'($urandom_range(0, 1023));
            last   = first + int'($urandom_range(0, 40));
            if (last > 1023) last = 1023;
            if ($urandom_range(0, 9) == 0 && first > 0) last = first - 1;
            stride = int'($urandom_range(0, 15));
            cont   = ($urandom_range(0, 3) == 0);
            start_scan(first, last, stride, cont);
            len = int'($urandom_range(20, 150));
            for (int j = 0; j < len; j++) begin
                int r;
                step();
                rst          = 1'b0;
                i_first_addr = AW'($urandom_range(0, 1023));
                i_last_addr  = AW'($urandom_range(0, 1023));
                i_stride     = 4'($urandom_range(0, 15));
                i_mode_cont  = $urandom_range(0, 1) == 1;
                r = int'($urandom_range(0, 199));
                if (r < 5) begin
                    i_abort = 1'b1;
                    model_abort(cyc);
                end else if (r < 11) begin
                    i_start_scan = 1'b1;
                    model_start(cyc, int'(i_first_addr), int'(i_last_addr),
                                int'(i_stride), i_mode_cont);
                end else if (r == 11) begin
                    rst = 1'b1;
                    model_reset(cyc);
                end
            end
            step();
            rst = 1'b0;
            if (o_busy) abort_now();
            wait_idle(300, "wait_random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
